// File: rtl/cgra_pkg.sv
// Shared CGRA types: configuration word and data tokens used by the tile control path.
`default_nettype none

package cgra_pkg;

  localparam int CFG_W = 49;

  typedef struct packed {
    logic [5:0]      ctrl;
    logic            predicate;
    logic [3:0][2:0] fu_in;
    logic [7:0][2:0] outport;
    logic [5:0]      predicate_in;
  } CGRAConfig_6_4_6_8;

  typedef struct packed {
    logic [31:0] payload;
    logic        predicate;
    logic        bypass;
  } CGRAData_32_1_1;

  typedef struct packed {
    logic payload;
    logic predicate;
  } CGRAData_1_1;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } seq_state_e;

endpackage

`default_nettype wire

// File: rtl/ctrl_mem_regfile.sv
// Flop-based configuration store: one write port, one combinational read port,
// asynchronously cleared to all-zero words.
`default_nettype none

module ctrl_mem_regfile
  import cgra_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  CGRAConfig_6_4_6_8 wr_data_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output CGRAConfig_6_4_6_8 rd_data_o
);

  CGRAConfig_6_4_6_8 mem_q [DEPTH];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  assign rd_data_o = mem_q[rd_addr_i];

endmodule

`default_nettype wire

// File: rtl/ctrl_mem_sequencer.sv
// Per-tile configuration sequencer: loads config words while idle, then streams
// them in address order to the crossbar for a programmed number of iterations.
`default_nettype none

module ctrl_mem_sequencer
  import cgra_pkg::*;
#(
  parameter int CTRL_MEM_SIZE = 8,
  parameter int ADDR_W        = $clog2(CTRL_MEM_SIZE),
  parameter int ITER_W        = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              recv_wr__en,
  input  logic [ADDR_W-1:0] recv_wr__addr,
  input  CGRAConfig_6_4_6_8 recv_wr__msg,
  output logic              recv_wr__rdy,
  input  logic              start__en,
  input  logic [ADDR_W-1:0] start__last,
  input  logic [ITER_W-1:0] start__iters,
  output logic              start__rdy,
  input  logic              stop,
  output logic              send_ctrl__en,
  output CGRAConfig_6_4_6_8 send_ctrl__msg,
  input  logic              send_ctrl__rdy,
  output logic              busy,
  output logic              done
);

  seq_state_e        state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] last_q, last_d;
  logic [ITER_W-1:0] rem_q, rem_d;
  logic              forever_q, forever_d;
  logic              done_q, done_d;
  logic              send_en;
  logic              wr_fire;

  assign wr_fire = recv_wr__en & (state_q == ST_IDLE);

  ctrl_mem_regfile #(
    .DEPTH  (CTRL_MEM_SIZE),
    .ADDR_W (ADDR_W)
  ) u_regfile (
    .clk       (clk),
    .reset     (reset),
    .wr_en_i   (wr_fire),
    .wr_addr_i (recv_wr__addr),
    .wr_data_i (recv_wr__msg),
    .rd_addr_i (pc_q),
    .rd_data_o (send_ctrl__msg)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      pc_q      <= '0;
      last_q    <= '0;
      rem_q     <= '0;
      forever_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      last_q    <= last_d;
      rem_q     <= rem_d;
      forever_q <= forever_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    last_d    = last_q;
    rem_d     = rem_q;
    forever_d = forever_q;
    done_d    = 1'b0;
    send_en   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start__en) begin
          pc_d      = '0;
          last_d    = start__last;
          rem_d     = start__iters;
          forever_d = (start__iters == '0);
          state_d   = ST_RUN;
        end
      end
      ST_RUN: begin
        send_en = send_ctrl__rdy & ~stop;
        if (stop) begin
          state_d = ST_IDLE;
        end else if (send_en) begin
          if (pc_q == last_q) begin
            pc_d = '0;
            // Zero iterations means free-running: rem is never consumed.
            if (!forever_q) begin
              rem_d = rem_q - ITER_W'(1);
              if (rem_q == ITER_W'(1)) begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
              end
            end
          end else begin
            pc_d = pc_q + ADDR_W'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign send_ctrl__en = send_en;
  assign busy          = (state_q == ST_RUN);
  assign recv_wr__rdy  = (state_q == ST_IDLE);
  assign start__rdy    = (state_q == ST_IDLE);
  assign done          = done_q;

endmodule

`default_nettype wire

// File: tb/tb_ctrl_mem_sequencer.sv
// Directed self-checking bench for ctrl_mem_sequencer.
`default_nettype none

module tb_ctrl_mem_sequencer;
  import cgra_pkg::*;

  localparam int SIZE = 8;
  localparam int AW   = 3;
  localparam int IW   = 8;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              wr_en = 1'b0;
  logic [AW-1:0]     wr_addr = '0;
  CGRAConfig_6_4_6_8 wr_msg = '0;
  logic              wr_rdy;
  logic              st_en = 1'b0;
  logic [AW-1:0]     st_last = '0;
  logic [IW-1:0]     st_iters = '0;
  logic              st_rdy;
  logic              stop = 1'b0;
  logic              s_en;
  CGRAConfig_6_4_6_8 s_msg;
  logic              s_rdy = 1'b0;
  logic              busy;
  logic              done;

  int checks = 0;
  int failures = 0;

  ctrl_mem_sequencer #(.CTRL_MEM_SIZE(SIZE), .ADDR_W(AW), .ITER_W(IW)) dut (
    .clk(clk), .reset(reset),
    .recv_wr__en(wr_en), .recv_wr__addr(wr_addr), .recv_wr__msg(wr_msg), .recv_wr__rdy(wr_rdy),
    .start__en(st_en), .start__last(st_last), .start__iters(st_iters), .start__rdy(st_rdy),
    .stop(stop), .send_ctrl__en(s_en), .send_ctrl__msg(s_msg), .send_ctrl__rdy(s_rdy),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  function automatic CGRAConfig_6_4_6_8 cfg(input logic [5:0] c);
    CGRAConfig_6_4_6_8 w;
    w.ctrl         = c;
    w.predicate    = c[0];
    w.fu_in        = {4{c[2:0]}};
    w.outport      = {8{c[5:3]}};
    w.predicate_in = ~c;
    return w;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_word(input logic [AW-1:0] a, input logic [5:0] c);
    wr_en = 1'b1; wr_addr = a; wr_msg = cfg(c);
    step();
    wr_en = 1'b0;
  endtask

  task automatic start_run(input logic [AW-1:0] last, input logic [IW-1:0] iters);
    st_en = 1'b1; st_last = last; st_iters = iters;
    step();
    st_en = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if ({busy, done, s_en, wr_rdy, st_rdy} !== 5'b00011) begin
      failures++;
      $display("FAIL reset_outputs got=%b want=00011", {busy, done, s_en, wr_rdy, st_rdy});
    end
    checks++;
    if (s_msg !== '0) begin
      failures++;
      $display("FAIL reset_msg got=%h want=0", s_msg);
    end
    reset = 1'b0;
    step();
  endtask

  task automatic test_stream();
    logic [5:0] exp [6] = '{6'h20, 6'h21, 6'h22, 6'h20, 6'h21, 6'h22};
    write_word(0, 6'h20); write_word(1, 6'h21); write_word(2, 6'h22);
    s_rdy = 1'b1;
    start_run(2, 2);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checks++;
      if (!(busy === 1'b1 && s_en === 1'b1 && s_msg === cfg(exp[i]))) begin
        failures++;
        $display("FAIL stream_beat%0d got busy=%b en=%b msg=%h want busy=1 en=1 msg=%h",
                 i, busy, s_en, s_msg, cfg(exp[i]));
      end
      step();
    end
    @(negedge clk);
    checks++;
    if ({busy, done, wr_rdy, st_rdy, s_en} !== 5'b01110) begin
      failures++;
      $display("FAIL stream_done got=%b want=01110", {busy, done, wr_rdy, st_rdy, s_en});
    end
    step();
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin
      failures++;
      $display("FAIL stream_done_pulse got=%b want=0", done);
    end
    step();
  endtask

  task automatic test_stall();
    logic [5:0] exp [6] = '{6'h20, 6'h21, 6'h22, 6'h20, 6'h21, 6'h22};
    int n = 0;
    int cyc = 0;
    bit seen_done = 0;
    bit en_bad = 0;
    s_rdy = 1'b1;
    start_run(2, 2);
    while (!seen_done && cyc < 40) begin
      s_rdy = (cyc % 3 == 0);
      @(negedge clk);
      if (busy && s_en !== s_rdy) en_bad = 1;
      if (s_en === 1'b1) begin
        checks++;
        if (n >= 6 || s_msg !== cfg(exp[n % 6])) begin
          failures++;
          $display("FAIL stall_xfer%0d got=%h want=%h", n, s_msg, cfg(exp[n % 6]));
        end
        n++;
      end
      if (done === 1'b1) seen_done = 1;
      step();
      cyc++;
    end
    checks++;
    if (!seen_done || n != 6) begin
      failures++;
      $display("FAIL stall_count got xfers=%0d done=%0d want xfers=6 done=1", n, seen_done);
    end
    checks++;
    if (en_bad) begin
      failures++;
      $display("FAIL stall_en_follows_rdy got=mismatch want=en==rdy");
    end
    s_rdy = 1'b1;
  endtask

  task automatic test_stop();
    write_word(0, 6'h3F);
    start_run(0, 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (s_en !== 1'b1 || s_msg !== cfg(6'h3F)) begin
        failures++;
        $display("FAIL stop_repeat%0d got en=%b msg=%h want en=1 msg=%h", i, s_en, s_msg, cfg(6'h3F));
      end
      step();
    end
    stop = 1'b1;
    @(negedge clk);
    checks++;
    if (s_en !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL stop_cycle got en=%b busy=%b want en=0 busy=1", s_en, busy);
    end
    step();
    stop = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if ({busy, done, s_en, st_rdy} !== 4'b0001) begin
        failures++;
        $display("FAIL stop_idle%0d got=%b want=0001", i, {busy, done, s_en, st_rdy});
      end
      step();
    end
  endtask

  task automatic test_write_in_run();
    logic [5:0] exp1 [6] = '{6'h20, 6'h21, 6'h22, 6'h20, 6'h21, 6'h22};
    logic [5:0] exp2 [3] = '{6'h20, 6'h2A, 6'h22};
    write_word(0, 6'h20);
    start_run(2, 2);
    wr_en = 1'b1; wr_addr = 1; wr_msg = cfg(6'h2A);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i == 0) begin
        checks++;
        if (wr_rdy !== 1'b0) begin
          failures++;
          $display("FAIL run_wr_rdy got=%b want=0", wr_rdy);
        end
      end
      checks++;
      if (s_msg !== cfg(exp1[i]) || s_en !== 1'b1) begin
        failures++;
        $display("FAIL run_write_ignored%0d got=%h want=%h", i, s_msg, cfg(exp1[i]));
      end
      step();
      if (i == 2) wr_en = 1'b0;
    end
    wr_en = 1'b0;
    step();
    write_word(1, 6'h2A);
    start_run(2, 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (s_msg !== cfg(exp2[i])) begin
        failures++;
        $display("FAIL idle_write_visible%0d got=%h want=%h", i, s_msg, cfg(exp2[i]));
      end
      step();
    end
    step();
  endtask

  task automatic test_reset_mid_run();
    start_run(2, 0);
    step();
    @(negedge clk);
    reset = 1'b1;
    #1;
    checks++;
    if ({busy, done, s_en, wr_rdy, st_rdy} !== 5'b00011 || s_msg !== '0) begin
      failures++;
      $display("FAIL async_reset got=%b msg=%h want=00011 msg=0", {busy, done, s_en, wr_rdy, st_rdy}, s_msg);
    end
    step();
    reset = 1'b0;
    step();
    start_run(2, 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (s_msg !== '0 || s_en !== 1'b1) begin
        failures++;
        $display("FAIL mem_cleared%0d got en=%b msg=%h want en=1 msg=0", i, s_en, s_msg);
      end
      step();
    end
    step();
  endtask

  task automatic test_write_and_start();
    wr_en = 1'b1; wr_addr = 0; wr_msg = cfg(6'h15);
    st_en = 1'b1; st_last = 0; st_iters = 1;
    step();
    wr_en = 1'b0; st_en = 1'b0;
    @(negedge clk);
    checks++;
    if (s_msg !== cfg(6'h15) || s_en !== 1'b1 || busy !== 1'b1) begin
      failures++;
      $display("FAIL wr_start_same_cycle got en=%b msg=%h want en=1 msg=%h", s_en, s_msg, cfg(6'h15));
    end
    step();
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL single_iter_done got done=%b busy=%b want done=1 busy=0", done, busy);
    end
    step();
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_stop();
    test_write_in_run();
    test_reset_mid_run();
    test_write_and_start();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
